// File: rtl/vbus_arbiter.sv
// Memory bus arbiter: the CPU owns the bus by default. The VPU DMA (high priority) and a
// burst-limited aux DMA take it over via the hold/ba handshake.
module vbus_arbiter #(
    parameter int AUX_MAX_BURST = 16,
    parameter int BA_TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_cs,
    input  logic        ba,
    output logic        hold,
    input  logic        req_vpu,
    input  logic [15:0] addr_vpu,
    input  logic        cs_vpu,
    output logic        gnt_vpu,
    input  logic        req_aux,
    input  logic [15:0] addr_aux,
    input  logic        cs_aux,
    output logic        gnt_aux,
    output logic [15:0] mem_addr,
    output logic        mem_cs,
    output logic [1:0]  owner,
    output logic        ba_err
);

    localparam logic [2:0] S_CPU   = 3'd0;
    localparam logic [2:0] S_HOLDW = 3'd1;
    localparam logic [2:0] S_GNT_V = 3'd2;
    localparam logic [2:0] S_GNT_A = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam logic [2:0] S_REL   = 3'd5;

    localparam int TW = $clog2(BA_TIMEOUT + 1);
    localparam int BW = $clog2(AUX_MAX_BURST + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(BA_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(BA_TIMEOUT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(AUX_MAX_BURST - 1);

    logic [2:0]    state, state_d;
    logic [TW-1:0] tcnt;
    logic [BW-1:0] bcnt;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            S_CPU:   if (req_vpu || req_aux) state_d = S_HOLDW;
            S_HOLDW: if (ba) state_d = req_vpu ? S_GNT_V : (req_aux ? S_GNT_A : S_REL);
            S_GNT_V: if (!req_vpu) state_d = S_TURN;
            S_GNT_A: if (!req_aux || (req_vpu && bcnt >= B_LAST)) state_d = S_TURN;
            S_TURN:  state_d = req_vpu ? S_GNT_V : (req_aux ? S_GNT_A : S_REL);
            S_REL:   if (!ba) state_d = S_CPU;
            default: state_d = S_CPU;
        endcase
    end

    // Outputs are registered from the next state so they change in step with the state register.
    // NOTE: sequential state uses non-blocking assignments only, avoiding races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CPU;
            hold    <= 1'b0;
            gnt_vpu <= 1'b0;
            gnt_aux <= 1'b0;
            owner   <= 2'd0;
            ba_err  <= 1'b0;
            tcnt    <= '0;
            bcnt    <= '0;
        end else begin
            state   <= state_d;
            hold    <= (state_d == S_HOLDW) || (state_d == S_GNT_V) ||
                       (state_d == S_GNT_A) || (state_d == S_TURN);
            gnt_vpu <= (state_d == S_GNT_V);
            gnt_aux <= (state_d == S_GNT_A);
            case (state_d)
                S_CPU:   owner <= 2'd0;
                S_GNT_V: owner <= 2'd1;
                S_GNT_A: owner <= 2'd2;
                default: owner <= 2'd3;
            endcase

            if (state == S_HOLDW && !ba) begin
                if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
                if (tcnt == T_LAST) ba_err <= 1'b1;
            end else begin
                tcnt <= '0;
            end

            // Losing ba while a DMA master owns the bus is a protocol violation; the grant is kept.
            if ((state == S_GNT_V || state == S_GNT_A) && !ba) ba_err <= 1'b1;

            if (state == S_GNT_A) begin
                if (bcnt != B_LAST) bcnt <= bcnt + 1'b1;
            end else begin
                bcnt <= '0;
            end
        end
    end

    always_comb begin
        mem_addr = cpu_addr;
        mem_cs   = 1'b0;
        case (state)
            S_CPU:   mem_cs = cpu_cs;
            S_GNT_V: begin mem_addr = addr_vpu; mem_cs = cs_vpu; end
            S_GNT_A: begin mem_addr = addr_aux; mem_cs = cs_aux; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vbus_arbiter.sv
// Directed bench for vbus_arbiter: latency, priority, aux burst preemption, ba timeout,
// reset mid-grant, and ba loss during a grant.
module tb_vbus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr, addr_vpu, addr_aux;
    logic        cpu_cs, cs_vpu, cs_aux;
    logic        ba, req_vpu, req_aux;
    logic        hold, gnt_vpu, gnt_aux, mem_cs, ba_err;
    logic [15:0] mem_addr;
    logic [1:0]  owner;

    int checks   = 0;
    int failures = 0;
    bit ba_auto  = 1'b1;
    bit started  = 1'b0;

    vbus_arbiter #(.AUX_MAX_BURST(16), .BA_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .ba(ba), .hold(hold),
        .req_vpu(req_vpu), .addr_vpu(addr_vpu), .cs_vpu(cs_vpu), .gnt_vpu(gnt_vpu),
        .req_aux(req_aux), .addr_aux(addr_aux), .cs_aux(cs_aux), .gnt_aux(gnt_aux),
        .mem_addr(mem_addr), .mem_cs(mem_cs), .owner(owner), .ba_err(ba_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; a well-behaved CPU answers hold with ba within the same cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (ba_auto) ba = hold;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("no_overlap", {31'd0, gnt_vpu & gnt_aux}, 32'd0);
            if (owner == 2'd3) check("cs_idle", {31'd0, mem_cs}, 32'd0);
            if (gnt_vpu || gnt_aux) check("gnt_needs_hold", {31'd0, hold}, 32'd1);
        end
    end

    initial begin
        int n;
        rst = 1'b1; ba = 1'b0; req_vpu = 1'b0; req_aux = 1'b0;
        cpu_addr = 16'h1234; addr_vpu = 16'h4000; addr_aux = 16'h8000;
        cpu_cs = 1'b1; cs_vpu = 1'b1; cs_aux = 1'b1;
        step(); step();
        rst = 1'b0;
        started = 1'b1;
        check("rst_hold", hold, 0);
        check("rst_gnt", {gnt_vpu, gnt_aux}, 0);
        check("rst_owner", owner, 0);
        check("rst_ba_err", ba_err, 0);
        check("rst_addr", mem_addr, 16'h1234);
        check("rst_cs", mem_cs, 1);

        // VPU latency and release sequence
        req_vpu = 1'b1;
        step();
        check("v_hold", hold, 1);
        check("v_owner_holdw", owner, 3);
        check("v_nogrant_yet", gnt_vpu, 0);
        step();
        check("v_gnt", gnt_vpu, 1);
        check("v_owner", owner, 1);
        check("v_addr", mem_addr, 16'h4000);
        check("v_cs", mem_cs, 1);
        req_vpu = 1'b0;
        step();
        check("v_turn_owner", owner, 3);
        check("v_turn_gnt", gnt_vpu, 0);
        check("v_turn_hold", hold, 1);
        step();
        check("v_rel_owner", owner, 3);
        check("v_rel_hold", hold, 0);
        step();
        check("v_cpu_owner", owner, 0);
        check("v_cpu_addr", mem_addr, 16'h1234);

        // Simultaneous requests: VPU first, then aux after TURN
        req_vpu = 1'b1; req_aux = 1'b1;
        step();
        step();
        check("p_vpu_first", {gnt_vpu, gnt_aux}, 2'b10);
        step();
        check("p_vpu_still", {gnt_vpu, gnt_aux}, 2'b10);
        req_vpu = 1'b0;
        step();
        check("p_turn", {gnt_vpu, gnt_aux}, 2'b00);
        step();
        check("p_aux_gnt", gnt_aux, 1);
        check("p_aux_owner", owner, 2);
        check("p_aux_addr", mem_addr, 16'h8000);

        // Burst limit: req_vpu raised at aux cycle 3, aux keeps the bus 16 cycles total
        n = 1;
        step(); n += int'(gnt_aux);
        step(); n += int'(gnt_aux);
        req_vpu = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!gnt_aux) break;
            n++;
        end
        check("b_len", n, 16);
        check("b_turn", {gnt_vpu, gnt_aux, owner}, {2'b00, 2'd3});
        step();
        check("b_vpu_gnt", gnt_vpu, 1);
        req_vpu = 1'b0;
        step();
        check("b_turn2", owner, 3);
        step();
        check("b_aux_again", gnt_aux, 1);
        req_aux = 1'b0;
        step(); step(); step();
        check("b_back_cpu", owner, 0);

        // ba timeout: 8 HOLDW cycles without ba
        ba_auto = 1'b0; ba = 1'b0;
        req_aux = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        check("t_no_err_7", ba_err, 0);
        step();
        check("t_err_8", ba_err, 1);
        check("t_no_gnt", gnt_aux, 0);
        check("t_still_hold", hold, 1);
        ba = 1'b1;
        step();
        check("t_late_gnt", gnt_aux, 1);
        check("t_err_sticky", ba_err, 1);

        // Reset mid-GNT_A
        rst = 1'b1;
        step();
        rst = 1'b0; req_aux = 1'b0; ba = 1'b0; ba_auto = 1'b1;
        check("r_hold", hold, 0);
        check("r_gnt", gnt_aux, 0);
        check("r_owner", owner, 0);
        check("r_addr", mem_addr, 16'h1234);
        check("r_err_clr", ba_err, 0);

        // ba loss while VPU holds the grant
        req_vpu = 1'b1;
        step(); step();
        check("l_gnt", gnt_vpu, 1);
        ba_auto = 1'b0; ba = 1'b0;
        step();
        check("l_gnt_kept", gnt_vpu, 1);
        check("l_err", ba_err, 1);
        req_vpu = 1'b0;
        step(); step(); step();
        check("l_back_cpu", owner, 0);

        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vbus_arbiter.md
Name: vbus_arbiter

Overview:
Arbitrates the 16-bit video/system memory bus between the CPU (default owner) and two DMA masters: the VPU line-fetch DMA (high priority) and an auxiliary DMA such as a blitter or sound fetcher (low priority, burst-limited). It asks the CPU to release the bus with hold/ba and issues grants to the DMA masters. It muxes the granted master's address and chip-select onto the memory bus. The VPU DMA's existing hold output drives req_vpu.

Parameters:
AUX_MAX_BURST, 16, max cycles the aux master keeps the bus while req_vpu is pending (>=1)
BA_TIMEOUT, 255, cycles in HOLDW without ba before ba_err is set (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_addr  in  16  CPU address
cpu_cs  in  1  CPU memory select
ba  in  1  CPU bus-available acknowledge (1 = CPU off bus)
hold  out  1  bus release request to CPU
req_vpu  in  1  VPU DMA bus request (level)
addr_vpu  in  16  VPU DMA address
cs_vpu  in  1  VPU DMA memory select
gnt_vpu  out  1  VPU DMA grant
req_aux  in  1  aux DMA bus request (level)
addr_aux  in  16  aux DMA address
cs_aux  in  1  aux DMA memory select
gnt_aux  out  1  aux DMA grant
mem_addr  out  16  memory address
mem_cs  out  1  memory select
owner  out  2  0=CPU, 1=VPU, 2=aux, 3=transition
ba_err  out  1  sticky: ba did not arrive within BA_TIMEOUT

Behaviour:
- One clock; reset is synchronous and active-high. Clock and reset ports are clk and rst.
- Registered outputs: hold, gnt_vpu, gnt_aux, owner, ba_err.
- Combinational outputs: mem_addr and mem_cs are muxes keyed on the registered state.
- Reset: state CPU, hold=0, gnt_*=0, owner=0, ba_err=0, burst and timeout counters=0.
- Reset mid-grant drops the grants and hold at that edge. The mux returns to the CPU.
- States:
  - CPU: hold=0, owner=0, mem_addr=cpu_addr, mem_cs=cpu_cs. If req_vpu|req_aux -> HOLDW.
  - HOLDW: hold=1, owner=3, mem_addr=cpu_addr, mem_cs=0. The timeout counter increments each cycle.
    - At count BA_TIMEOUT, ba_err<=1 and the block keeps waiting.
    - On ba=1: if req_vpu, GNT_V; else if req_aux, GNT_A; else REL (requests withdrawn). The timeout counter clears.
  - GNT_V: gnt_vpu=1, owner=1, mem_addr=addr_vpu, mem_cs=cs_vpu. Unlimited tenure. When req_vpu=0 -> TURN.
  - GNT_A: gnt_aux=1, owner=2, mem_addr=addr_aux, mem_cs=cs_aux. The burst counter starts at 0 and increments each cycle.
    - If req_aux=0 -> TURN.
    - Else if req_vpu=1 and burst counter >= AUX_MAX_BURST-1 -> TURN (preempt).
    - The burst counter saturates and is not compared while req_vpu=0.
  - TURN: one dead cycle. gnt_*=0, mem_cs=0, hold=1, owner=3. Then: req_vpu -> GNT_V; else req_aux -> GNT_A; else REL.
    - After preemption the aux master re-enters GNT_A once req_vpu drops; req_aux remains asserted.
  - REL: hold=0, mem_cs=0, owner=3. -> CPU when ba=0. Requests arriving in REL are serviced from CPU on the next cycle.
- Grants are only asserted while hold=1 and ba was seen. No grant overlaps another, and grant changes are always separated by at least one TURN cycle.
- Priority: VPU over aux at every decision point, with no fairness toward aux beyond the burst limit.
- Latency: with ba returned one cycle after hold, req_vpu high at edge N gives hold=1 after N, ba=1 sampled at N+1, and gnt_vpu=1 after N+1.
- ba dropping while in GNT_V or GNT_A is a protocol violation. The grant is held and ba_err is set.
- Requester deasserting req without seeing a grant: the arbiter re-evaluates at the next decision point. A drop during HOLDW with no other request leads to REL.

Test Plan:
- Reset mid-GNT_A (rst=1 for 1 cycle) -> next cycle hold=0, gnt_aux=0, owner=0, mem_addr=cpu_addr.
- req_vpu=1 from CPU state, ba follows hold by 1 cycle -> hold=1 after 1 edge, gnt_vpu=1 after 2 edges, mem_addr=addr_vpu=16'h4000. Drop req_vpu -> TURN, REL, CPU; owner sequence 1,3,3,0.
- req_aux=1 and req_vpu=1 together -> gnt_vpu first; aux granted only after TURN once req_vpu=0.
- Aux granted, req_vpu raised at aux cycle 3, AUX_MAX_BURST=16 -> gnt_aux high for exactly 16 cycles, 1 TURN cycle, then gnt_vpu=1. After req_vpu drops, TURN then gnt_aux=1 again.
- ba held 0 in HOLDW, BA_TIMEOUT=8 -> ba_err=1 after 8 cycles and no grant. Then ba=1 -> grant issued; ba_err stays 1 until rst.
- Throughout all tests, assert mem_cs=0 in HOLDW, TURN and REL, and assert never gnt_vpu&gnt_aux.
